// File: rtl/tdes_pkg.sv
// Shared types and constants for the iterative Triple-DES round controller.
// The two-key option (TDES_KEYING2_EN) is applied in tdes_round_ctrl.
package tdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PASS_END,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    K1 = 2'd0,
    K2 = 2'd1,
    K3 = 2'd2
  } key_sel_e;

  localparam int DES_ROUNDS = 16;

  // Per-round key rotation for an encipher pass; a decipher pass skips round 0.
  localparam logic [1:0] SHIFT_SCHED [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // EDE key order: encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
  function automatic key_sel_e pass_key(input logic [1:0] pass, input logic decrypt,
                                        input logic three_pass);
    if (decrypt && three_pass) return key_sel_e'(2'd2 - pass);
    return key_sel_e'(pass);
  endfunction

  // Middle pass runs in the opposite direction to the outer passes.
  function automatic logic pass_dir(input logic [1:0] pass, input logic decrypt);
    return decrypt ^ pass[0];
  endfunction

endpackage

// File: rtl/tdes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the Triple-DES sequencer
// (slave) and its environment (master).
interface tdes_round_ctrl_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic       DECRYPT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       LOAD_DATA;
  logic       ROUND_EN;
  logic       PASS_SWAP;
  logic       KEY_LOAD;
  logic [1:0] KEY_SEL;
  logic       KEY_DIR;
  logic [1:0] SHIFT_AMT;
  logic [3:0] ROUND;
  logic [1:0] PASS;

  modport master (
    output IN_VALID, DECRYPT, OUT_READY,
    input  IN_READY, OUT_VALID, LOAD_DATA, ROUND_EN, PASS_SWAP, KEY_LOAD,
           KEY_SEL, KEY_DIR, SHIFT_AMT, ROUND, PASS
  );

  modport slave (
    input  IN_VALID, DECRYPT, OUT_READY,
    output IN_READY, OUT_VALID, LOAD_DATA, ROUND_EN, PASS_SWAP, KEY_LOAD,
           KEY_SEL, KEY_DIR, SHIFT_AMT, ROUND, PASS
  );
endinterface

// File: rtl/des_key_shift_lut.sv
// Key-schedule rotation amount for the current round and pass direction.
module des_key_shift_lut
  import tdes_pkg::*;
(
  input  logic [3:0] ROUND,
  input  logic       KEY_DIR,
  output logic [1:0] SHIFT_AMT
);

  // Table lookup; a decipher pass starts from the unrotated key at round 0.
  always_comb begin
    SHIFT_AMT = SHIFT_SCHED[ROUND];
    if (KEY_DIR && (ROUND == 4'd0)) SHIFT_AMT = 2'd0;
  end

endmodule

// File: rtl/tdes_round_ctrl.sv
// Iterative Triple-DES sequencer driving one shared DES round datapath:
// NUM_PASSES x 16 rounds in EDE order with a one-cycle boundary between passes.
// Optional macro TDES_KEYING2_EN: two-key Triple-DES (K3 aliases K1).
module tdes_round_ctrl
  import tdes_pkg::*;
#(
  parameter int NUM_PASSES = 3
) (
  input logic              CLK,
  input logic              RST,
  tdes_round_ctrl_if.slave ctl
);

  if ((NUM_PASSES != 1) && (NUM_PASSES != 3)) begin : g_bad_num_passes
    $error("tdes_round_ctrl: NUM_PASSES must be 1 or 3");
  end

  localparam logic       THREE_PASS = (NUM_PASSES == 3);
  localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

  function automatic key_sel_e map_key(input key_sel_e k);
`ifdef TDES_KEYING2_EN
    return (k == K3) ? K1 : k;
`else
    return k;
`endif
  endfunction

  state_e     state;
  logic [3:0] round_q;
  logic [1:0] pass_q;
  logic       decrypt_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       load_data_q;
  logic       round_en_q;
  logic       pass_swap_q;
  logic       key_load_q;
  key_sel_e   key_sel_q;
  logic       key_dir_q;
  logic [1:0] lut_amt;
  logic [1:0] next_pass;

  assign next_pass = pass_q + 2'd1;

  // Sequencer: state, counters and every output strobe registered together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      round_q     <= '0;
      pass_q      <= '0;
      decrypt_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      load_data_q <= 1'b0;
      round_en_q  <= 1'b0;
      pass_swap_q <= 1'b0;
      key_load_q  <= 1'b0;
      key_sel_q   <= K1;
      key_dir_q   <= 1'b0;
    end else begin
      load_data_q <= 1'b0;
      pass_swap_q <= 1'b0;
      key_load_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctl.IN_VALID) begin
            state       <= LOAD;
            decrypt_q   <= ctl.DECRYPT;
            in_ready_q  <= 1'b0;
            load_data_q <= 1'b1;
            key_load_q  <= 1'b1;
            round_q     <= '0;
            pass_q      <= '0;
            key_sel_q   <= map_key(pass_key(2'd0, ctl.DECRYPT, THREE_PASS));
            key_dir_q   <= pass_dir(2'd0, ctl.DECRYPT);
          end
        end
        LOAD, PASS_END: begin
          state      <= RUN;
          round_en_q <= 1'b1;
        end
        RUN: begin
          if (round_q == LAST_ROUND) begin
            round_en_q <= 1'b0;
            round_q    <= '0;
            if (pass_q == LAST_PASS) begin
              state       <= OUT;
              out_valid_q <= 1'b1;
              pass_q      <= '0;
              key_sel_q   <= K1;
              key_dir_q   <= 1'b0;
            end else begin
              state       <= PASS_END;
              pass_swap_q <= 1'b1;
              key_load_q  <= 1'b1;
              pass_q      <= next_pass;
              key_sel_q   <= map_key(pass_key(next_pass, decrypt_q, THREE_PASS));
              key_dir_q   <= pass_dir(next_pass, decrypt_q);
            end
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        OUT: begin
          if (ctl.OUT_READY) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  des_key_shift_lut u_shift_lut (
    .ROUND    (round_q),
    .KEY_DIR  (key_dir_q),
    .SHIFT_AMT(lut_amt)
  );

  assign ctl.IN_READY  = in_ready_q;
  assign ctl.OUT_VALID = out_valid_q;
  assign ctl.LOAD_DATA = load_data_q;
  assign ctl.ROUND_EN  = round_en_q;
  assign ctl.PASS_SWAP = pass_swap_q;
  assign ctl.KEY_LOAD  = key_load_q;
  assign ctl.KEY_SEL   = key_sel_q;
  assign ctl.KEY_DIR   = key_dir_q;
  // ROUND_EN is high exactly while in RUN, so it doubles as the shift-valid gate.
  assign ctl.SHIFT_AMT = round_en_q ? lut_amt : 2'd0;
  assign ctl.ROUND     = round_q;
  assign ctl.PASS      = pass_q;

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Self-checking bench for tdes_round_ctrl: cycle-by-cycle comparison of all
// outputs against a timeline model derived from pass/round arithmetic.
// Honours TDES_KEYING2_EN and a NUM_PASSES override the same way as the DUT.
module tb_tdes_round_ctrl;
  parameter int NUM_PASSES = 3;
  localparam int LAT = 17 * NUM_PASSES + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  tdes_round_ctrl_if bus ();

  tdes_round_ctrl #(.NUM_PASSES(NUM_PASSES)) dut (
    .CLK(clk),
    .RST(rst),
    .ctl(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit [1:0] key_of(input int p, input bit dec);
    bit [1:0] enc_keys [3] = '{2'd0, 2'd1, 2'd2};
    bit [1:0] dec_keys [3] = '{2'd2, 2'd1, 2'd0};
    bit [1:0] k;
    if (NUM_PASSES == 1) k = 2'd0;
    else k = dec ? dec_keys[p] : enc_keys[p];
`ifdef TDES_KEYING2_EN
    if (k == 2'd2) k = 2'd0;
`endif
    return k;
  endfunction

  function automatic bit dir_of(input int p, input bit dec);
    bit enc_dirs [3] = '{1'b0, 1'b1, 1'b0};
    bit dec_dirs [3] = '{1'b1, 1'b0, 1'b1};
    if (NUM_PASSES == 1) return dec;
    return dec ? dec_dirs[p] : enc_dirs[p];
  endfunction

  function automatic bit [1:0] shift_of(input int r, input bit d);
    if (d && r == 0) return 2'd0;
    if (r == 0 || r == 1 || r == 8 || r == 15) return 2'd1;
    return 2'd2;
  endfunction

  // Expected outputs k cycles after acceptance (k=0: idle).
  function automatic logic [16:0] exp_vec(input int k, input bit dec);
    bit ir = 0, ov = 0, ld = 0, re = 0, sw = 0, kl = 0, kd = 0;
    bit [1:0] ks = 0, sa = 0, ps = 0;
    bit [3:0] rd = 0;
    int t, p, r;
    if (k == 0) ir = 1;
    else if (k == 1) begin
      ld = 1; kl = 1; ks = key_of(0, dec); kd = dir_of(0, dec);
    end else if (k >= LAT) ov = 1;
    else begin
      t = k - 2; p = t / 17; r = t % 17;
      if (r < 16) begin
        re = 1; rd = 4'(r); ps = 2'(p);
        ks = key_of(p, dec); kd = dir_of(p, dec); sa = shift_of(r, kd);
      end else begin
        sw = 1; kl = 1; ps = 2'(p + 1);
        ks = key_of(p + 1, dec); kd = dir_of(p + 1, dec);
      end
    end
    return {ir, ov, ld, re, sw, kl, ks, kd, sa, rd, ps};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.IN_READY, bus.OUT_VALID, bus.LOAD_DATA, bus.ROUND_EN, bus.PASS_SWAP,
            bus.KEY_LOAD, bus.KEY_SEL, bus.KEY_DIR, bus.SHIFT_AMT, bus.ROUND, bus.PASS};
  endfunction

  // Runs one block from idle; starts and ends just after a rising edge.
  task automatic run_trace(input bit dec, input int unsigned out_wait, input bit noise,
                           input string name);
    logic [16:0] got, want;
    bus.IN_VALID  = 1'b1;
    bus.DECRYPT   = dec;
    bus.OUT_READY = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    got = obs(); want = exp_vec(0, dec); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s_idle: got %b expected %b", name, got, want);
    end
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      bus.IN_VALID = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.DECRYPT  = 1'($urandom_range(0, 1));
      if (k == LAT) bus.OUT_READY = (out_wait == 0);
      else if (noise) bus.OUT_READY = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = obs(); want = exp_vec(k, dec); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, got, want);
      end
    end
    for (int unsigned w = 1; w <= out_wait; w++) begin
      @(posedge clk); #1;
      bus.IN_VALID  = noise ? 1'(w[0]) : 1'b0;
      bus.OUT_READY = (w == out_wait);
      @(negedge clk);
      got = obs(); want = exp_vec(LAT, dec); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s_hold wait %0d: got %b expected %b", name, w, got, want);
      end
    end
    @(posedge clk); #1;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    @(negedge clk);
    got = obs(); want = exp_vec(0, dec); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s_release: got %b expected %b", name, got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [16:0] got, want;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      bus.IN_VALID  = 1'($urandom_range(0, 1));
      bus.OUT_READY = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    got = obs(); want = exp_vec(0, 1'b0); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b", got, want);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    @(negedge clk);
    got = obs(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_released: got %b expected %b", got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    run_trace(1'b0, 0, 1'b0, "encrypt");
  endtask

  task automatic test_decrypt();
    run_trace(1'b1, 0, 1'b0, "decrypt");
  endtask

  task automatic test_backpressure();
    run_trace(1'($urandom_range(0, 1)), 10, 1'b1, "backpressure");
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, want;
    int p_len = LAT + 1;
    bit d0 = 1'($urandom_range(0, 1));
    bit d1 = ~d0;
    bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1; bus.DECRYPT = d0;
    for (int k = 1; k <= 2 * p_len; k++) begin
      @(posedge clk); #1;
      if (k == p_len) bus.DECRYPT = d1;
      if (k == 2 * p_len) bus.IN_VALID = 1'b0;
      @(negedge clk);
      got = obs(); want = exp_vec(k % p_len, (k < p_len) ? d0 : d1); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, got, want);
      end
    end
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset_mid_block();
    logic [16:0] got, want;
    bit dec = 1'($urandom_range(0, 1));
    bus.IN_VALID = 1'b1; bus.DECRYPT = dec; bus.OUT_READY = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      bus.IN_VALID = 1'b0;
      if (k == 25) rst = 1'b1;
      @(negedge clk);
      got = obs(); want = exp_vec(k, dec); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", k, got, want);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got = obs(); want = exp_vec(0, dec); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mid_block: got %b expected %b", got, want);
    end
    @(posedge clk); #1;
    run_trace(1'($urandom_range(0, 1)), 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [16:0] got, want;
    for (int b = 0; b < 30; b++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(negedge clk);
        got = obs(); want = exp_vec(0, 1'b0); checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL random_gap block %0d: got %b expected %b", b, got, want);
        end
        @(posedge clk); #1;
      end
      run_trace(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.IN_VALID = 1'b0; bus.DECRYPT = 1'b0; bus.OUT_READY = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
